audio_frame_scheduler: RTL and testbench
========================================

AUDIO_FRAME_SCHEDULER -- requirements
Module: audio_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, giving samples per FFT frame; power of two, range 16..4096.
REQ-002 SHALL have parameter SAMPLE_W, default 24, giving the I2S sample width in bits.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth for the I2S inputs.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: MCLK in 1, system clock, 50 MHz; RESET in 1, async active-low reset.
REQ-005 SHALL have these I2S inputs from the codec, all asynchronous to MCLK: AUD_BCLK in 1, bit clock; AUD_LRC in 1, LR clock, low = left; AUD_ADC_DATA in 1, serial data, MSB first.
REQ-006 SHALL have these sample-buffer write ports: buf_wr_en out 1; buf_wr_addr out log2(FRAME_LEN); buf_wr_data out SAMPLE_W, signed; buf_bank out 1, the ping-pong bank being written.
REQ-007 SHALL have these FFT handshake ports: fft_start out 1; fft_ready in 1; fft_done in 1, one-cycle pulse; fft_bank out 1, the bank the FFT reads.
REQ-008 SHALL have output overrun out 1, a sticky dropped-frame flag.

Function
REQ-009 SHALL synchronise AUD_BCLK, AUD_LRC and AUD_ADC_DATA through SYNC_STAGES flops and detect AUD_BCLK rising edges and AUD_LRC edges in MCLK.
REQ-010 SHALL sample data on AUD_BCLK rising edges with the I2S one-bit delay: the MSB is the 2nd rising edge after an LRC transition.
REQ-011 SHALL shift in SAMPLE_W bits per channel and ignore any further bits in that LRC half-period.
REQ-012 SHALL discard a partial sample when LRC toggles before SAMPLE_W bits have arrived; no write occurs.
REQ-013 SHALL assert buf_wr_en for exactly one MCLK cycle per completed left sample.
REQ-014 SHALL assert that write exactly SYNC_STAGES+2 MCLK cycles after the LSB-carrying BCLK rising edge reaches the pin.
REQ-015 SHALL hold buf_wr_addr at the write-sample count, 0..FRAME_LEN-1, incrementing after each write and wrapping to 0.
REQ-016 SHALL declare a frame complete on the cycle after the write with address FRAME_LEN-1.
REQ-017 SHALL run an FFT handshake FSM with states F_IDLE, F_REQ and F_BUSY:
- F_IDLE -> F_REQ on frame complete;
- F_REQ -> F_BUSY when fft_start && fft_ready;
- F_BUSY -> F_IDLE on fft_done.
REQ-018 SHALL drive fft_start high only in F_REQ and hold it high until fft_ready is sampled high.
REQ-019 SHALL, on frame complete in F_IDLE, toggle buf_bank and load fft_bank with the old buf_bank in the same cycle.
REQ-020 SHALL, on frame complete outside F_IDLE, drop the frame: set overrun, keep buf_bank, issue no fft_start, and restart the same bank at address 0.
REQ-021 SHALL, when fft_done and frame complete coincide, process fft_done first, treat the FSM as F_IDLE, and swap with no overrun.
REQ-022 SHALL clear overrun only on reset.

Reset
REQ-023 SHALL clear all outputs to 0 on RESET low, at any point including mid-sample: buf_wr_en, buf_wr_addr, buf_wr_data, buf_bank, fft_start, fft_bank and overrun.
REQ-024 SHALL also reset the FSM to F_IDLE, clear the shift register, bit counter and synchronisers, and clear the partial frame.
REQ-025 SHALL start capture after reset release only on the next AUD_LRC falling edge.

Configuration
REQ-026 SHALL support macro MONO_SUM_EN:
- defined: capture both channels and write (L+R)>>>1 (sign-correct, SAMPLE_W+1 intermediate) on completion of the right sample;
- undefined: write the left sample only and ignore right-channel bits.

Structure
REQ-027 SHALL define in package audio_sched_pkg: the SAMPLE_W and FRAME_LEN defaults, the FSM state enum (F_IDLE/F_REQ/F_BUSY) and a sample typedef (signed SAMPLE_W).
REQ-028 SHALL implement synchronisers, edge detect, bit counter and shift register in sub-module i2s_rx_deser, outputting sample, channel and a one-cycle valid; the parent holds the address/bank/FSM logic.

Verification
REQ-029 SHALL cover: reset release, left sample 24'h000001 -> one buf_wr_en, addr 0, data 24'h000001, latency SYNC_STAGES+2 cycles.
REQ-030 SHALL cover: left ramp 0..255 with FRAME_LEN=256 and fft_ready=1 -> writes at addr n with data n, one fft_start, fft_bank=0, buf_bank=1.
REQ-031 SHALL cover: fft_done withheld for a 2nd full frame -> overrun=1, buf_bank stays 1, no 2nd fft_start, 3rd frame writes from addr 0.
REQ-032 SHALL cover: fft_done in the same cycle as frame complete -> swap, fft_start asserted next cycle, overrun=0.
REQ-033 SHALL cover: RESET low after 10 of 24 bits -> all outputs 0; after release, first write is at addr 0 with no partial write.
REQ-034 SHALL cover: with MONO_SUM_EN, L=24'h000010 and R=24'hFFFFF0 -> buf_wr_data=24'h000000; with L=R=24'h7FFFFF -> 24'h7FFFFF.

Source files
------------

// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg: shared defaults, FFT handshake states and sample type
// for the audio frame scheduler.
package audio_sched_pkg;

   localparam int SAMPLE_W_DEFAULT  = 24;
   localparam int FRAME_LEN_DEFAULT = 256;

   typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_BUSY
   } fft_state_t;

endpackage

// File: rtl/audio_frame_scheduler_i2s_rx_deser.sv
// i2s_rx_deser: synchronises the I2S pins into MCLK and shifts in one
// sample per LRC half-period, MSB first after the one-bit I2S delay.
module i2s_rx_deser
   import audio_sched_pkg::*;
#(
   parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bclk,
   input  logic                       lrc,
   input  logic                       din,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       channel,
   output logic                       valid
);

   localparam int CW = $clog2(SAMPLE_W + 1);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_W - 1);
   localparam logic [CW-1:0] FULL = CW'(SAMPLE_W);

   logic [SYNC_STAGES-1:0] bclk_q, lrc_q, din_q;
   logic                   bclk_s, lrc_s, din_s;
   logic                   bclk_d, lrc_d;
   logic                   rise, lrc_edge, lrc_fall;
   logic                   armed, skip;
   logic [CW-1:0]          cnt;
   logic [SAMPLE_W-2:0]    shreg;

   assign bclk_s   = bclk_q[SYNC_STAGES-1];
   assign lrc_s    = lrc_q[SYNC_STAGES-1];
   assign din_s    = din_q[SYNC_STAGES-1];
   assign rise     = bclk_s & ~bclk_d;
   assign lrc_edge = lrc_s ^ lrc_d;
   assign lrc_fall = lrc_d & ~lrc_s;

   // synchroniser chains plus one delay tap for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_q <= '0;
         lrc_q  <= '0;
         din_q  <= '0;
         bclk_d <= 1'b0;
         lrc_d  <= 1'b0;
      end else begin
         bclk_q[0] <= bclk;
         lrc_q[0]  <= lrc;
         din_q[0]  <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            bclk_q[i] <= bclk_q[i-1];
            lrc_q[i]  <= lrc_q[i-1];
            din_q[i]  <= din_q[i-1];
         end
         bclk_d <= bclk_s;
         lrc_d  <= lrc_s;
      end
   end

   // bit counter and shifter; an LRC edge drops any partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed   <= 1'b0;
         skip    <= 1'b0;
         cnt     <= '0;
         shreg   <= '0;
         sample  <= '0;
         channel <= 1'b0;
         valid   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (lrc_fall)
            armed <= 1'b1;
         if (lrc_edge) begin
            skip <= 1'b1;
            cnt  <= '0;
         end else if (rise && armed && cnt < FULL) begin
            if (skip) begin
               skip <= 1'b0;
            end else begin
               shreg <= {shreg[SAMPLE_W-3:0], din_s};
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sample  <= {shreg, din_s};
                  channel <= lrc_s;
                  valid   <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler: I2S capture into a ping-pong frame buffer with
// FFT handshake; define MONO_SUM_EN to write (L+R)>>>1 instead of L.
module audio_frame_scheduler
   import audio_sched_pkg::*;
#(
   parameter int FRAME_LEN   = FRAME_LEN_DEFAULT,
   parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         MCLK,
   input  logic                         RESET,
   input  logic                         AUD_BCLK,
   input  logic                         AUD_LRC,
   input  logic                         AUD_ADC_DATA,
   output logic                         buf_wr_en,
   output logic [$clog2(FRAME_LEN)-1:0] buf_wr_addr,
   output logic signed [SAMPLE_W-1:0]   buf_wr_data,
   output logic                         buf_bank,
   output logic                         fft_start,
   input  logic                         fft_ready,
   input  logic                         fft_done,
   output logic                         fft_bank,
   output logic                         overrun
);

   localparam int AW = $clog2(FRAME_LEN);
   localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

   logic signed [SAMPLE_W-1:0] rx_sample;
   logic                       rx_channel, rx_valid;
   logic                       wr_go;
   logic signed [SAMPLE_W-1:0] wr_val;
   logic                       frame_done;
   fft_state_t                 state, eff, next;
   logic                       swap, drop;

   i2s_rx_deser #(
      .SAMPLE_W   (SAMPLE_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx (
      .clk    (MCLK),
      .rst_n  (RESET),
      .bclk   (AUD_BCLK),
      .lrc    (AUD_LRC),
      .din    (AUD_ADC_DATA),
      .sample (rx_sample),
      .channel(rx_channel),
      .valid  (rx_valid)
   );

`ifdef MONO_SUM_EN
   logic signed [SAMPLE_W-1:0] left;
   logic [SAMPLE_W:0]          sum;

   assign sum    = {rx_sample[SAMPLE_W-1], rx_sample}
                 + {left[SAMPLE_W-1], left};
   assign wr_go  = rx_valid & rx_channel;
   assign wr_val = sum[SAMPLE_W:1];

   // hold the latest left word until its right partner completes
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET)
         left <= '0;
      else if (rx_valid && !rx_channel)
         left <= rx_sample;
   end
`else
   assign wr_go  = rx_valid & ~rx_channel;
   assign wr_val = rx_sample;
`endif

   // write strobe, address counter and frame-complete flag
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         buf_wr_en   <= 1'b0;
         buf_wr_data <= '0;
         buf_wr_addr <= '0;
         frame_done  <= 1'b0;
      end else begin
         buf_wr_en  <= wr_go;
         frame_done <= buf_wr_en && buf_wr_addr == LAST;
         if (wr_go)
            buf_wr_data <= wr_val;
         if (buf_wr_en)
            buf_wr_addr <= buf_wr_addr + AW'(1);
      end
   end

   assign fft_start = (state == F_REQ);

   // next state; a coincident fft_done frees the FFT before the frame
   always_comb begin
      eff  = state;
      next = state;
      swap = 1'b0;
      drop = 1'b0;
      if (state == F_BUSY && fft_done)
         eff = F_IDLE;
      next = eff;
      unique case (eff)
         F_IDLE: begin
            if (frame_done) begin
               next = F_REQ;
               swap = 1'b1;
            end
         end
         F_REQ: begin
            if (fft_ready)
               next = F_BUSY;
            drop = frame_done;
         end
         F_BUSY: drop = frame_done;
         default: next = F_IDLE;
      endcase
   end

   // state, bank swap and sticky overrun
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         state    <= F_IDLE;
         buf_bank <= 1'b0;
         fft_bank <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state <= next;
         if (swap) begin
            buf_bank <= ~buf_bank;
            fft_bank <= buf_bank;
         end
         if (drop)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb_audio_frame_scheduler: random I2S traffic against a frame-level
// reference model, with a queue scoreboard for writes and FFT starts.
module tb_audio_frame_scheduler;
   import audio_sched_pkg::*;

   localparam int FL  = 32;
   localparam int SW  = 24;
   localparam int SS  = 2;
   localparam int AW  = $clog2(FL);
   localparam int LAT = SS + 2;

   logic mclk = 0, rst_n = 1;
   logic bclk = 0, lrc = 0, din = 0;
   logic fft_ready = 0, fft_done = 0;
   logic          buf_wr_en, buf_bank, fft_start, fft_bank, overrun;
   logic [AW-1:0] buf_wr_addr;
   logic [SW-1:0] buf_wr_data;

   audio_frame_scheduler #(
      .FRAME_LEN(FL), .SAMPLE_W(SW), .SYNC_STAGES(SS)
   ) dut (
      .MCLK(mclk), .RESET(rst_n),
      .AUD_BCLK(bclk), .AUD_LRC(lrc), .AUD_ADC_DATA(din),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
      .buf_wr_data(buf_wr_data), .buf_bank(buf_bank),
      .fft_start(fft_start), .fft_ready(fft_ready),
      .fft_done(fft_done), .fft_bank(fft_bank), .overrun(overrun)
   );

   always #10 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   typedef struct {
      int            addr;
      logic [SW-1:0] data;
      bit            bank;
      int            cyc;
   } wr_t;

   wr_t exp_wr[$];
   bit  exp_hs[$];
   int  errors = 0, checks = 0;

   int      m_count, m_total = 0;
   bit      m_bank, m_fftb, m_busy, m_armed, m_over, m_coincide;
   sample_t m_left;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [SW-1:0] mono(sample_t l, sample_t r);
      int s;
      s = int'(l) + int'(r);
      return SW'(s >>> 1);
   endfunction

   task automatic model_reset();
      m_count = 0; m_bank = 0; m_fftb = 0; m_busy = 0;
      m_armed = 0; m_over = 0; m_coincide = 0; m_left = '0;
      exp_wr.delete();
      exp_hs.delete();
   endtask

   // A complete word landed on the pins at cycle c.
   task automatic model_sample(input bit ch, input sample_t v,
                               input int c);
      wr_t e;
      if (!m_armed) return;
`ifdef MONO_SUM_EN
      if (!ch) begin
         m_left = v;
         return;
      end
      e.data = mono(m_left, v);
`else
      if (ch) return;
      e.data = v;
`endif
      e.addr = m_count;
      e.bank = m_bank;
      e.cyc  = c + LAT;
      exp_wr.push_back(e);
      m_total++;
      if (m_count == FL - 1) begin
         if (m_coincide) begin
            m_busy = 0;
            m_coincide = 0;
         end
         if (!m_busy) begin
            exp_hs.push_back(m_bank);
            m_fftb = m_bank;
            m_bank = ~m_bank;
            m_busy = 1;
         end else begin
            m_over = 1;
         end
         m_count = 0;
      end else begin
         m_count++;
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic send_chan(input bit ch, input sample_t v,
                            input int nbits);
      int hp, extra;
      hp    = $urandom_range(2, 3);
      extra = (nbits == SW) ? $urandom_range(0, 2) : 0;
      if (lrc && !ch) m_armed = 1;
      for (int s = 0; s <= nbits + extra; s++) begin
         bclk = 0;
         if (s == 0) lrc = ch;
         din = (s >= 1 && s <= nbits) ? v[SW-s] : 1'($urandom);
         hold(hp);
         bclk = 1;
         if (s == SW) model_sample(ch, v, cyc);
         hold(hp);
      end
   endtask

   task automatic send_frame(input sample_t l, input sample_t r,
                             input int lbits);
      send_chan(0, l, lbits);
      send_chan(1, r, SW);
   endtask

   task automatic send_writes(input int n, input bit ramp,
                              input bit trunc);
      int target, k, lb;
      target = m_total + n;
      k = 0;
      while (m_total < target && k < 4 * n) begin
         if (ramp) begin
            send_frame(sample_t'(k), sample_t'(k), SW);
         end else begin
            lb = (trunc && $urandom_range(0, 7) == 0)
               ? $urandom_range(1, SW - 1) : SW;
            send_frame(sample_t'($urandom), sample_t'($urandom), lb);
         end
         k++;
      end
      check("writes_issued", m_total, target);
   endtask

   task automatic check_zero();
      check("rst_wr_en", buf_wr_en, 0);
      check("rst_wr_addr", buf_wr_addr, 0);
      check("rst_wr_data", buf_wr_data, 0);
      check("rst_buf_bank", buf_bank, 0);
      check("rst_fft_start", fft_start, 0);
      check("rst_fft_bank", fft_bank, 0);
      check("rst_overrun", overrun, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      check_zero();
      hold(3);
      rst_n = 1;
      model_reset();
      hold(2);
   endtask

   task automatic issue_done();
      int n = 0;
      while (fft_start && n < 200) begin
         hold(1);
         n++;
      end
      check("done_wait_busy", n < 200, 1);
      fft_done = 1;
      hold(1);
      fft_done = 0;
      m_busy = 0;
   endtask

   task automatic done_at_complete();
      int n = 0;
      while (!(buf_wr_en && buf_wr_addr == AW'(FL - 1)) && n < 20000) begin
         @(negedge mclk);
         n++;
      end
      check("coincide_wait", n < 20000, 1);
      @(posedge mclk);
      #1 fft_done = 1;
      @(posedge mclk);
      #1 fft_done = 0;
      @(negedge mclk);
      check("start_after_coincide", fft_start, 1);
      check("overrun_coincide", overrun, 0);
   endtask

   initial forever begin
      @(posedge mclk);
      #1 fft_ready = 1'($urandom_range(0, 1));
   end

   // scoreboard monitor
   initial begin
      wr_t e;
      bit  hs;
      logic prev_start = 0, prev_ready = 0;
      forever begin
         @(negedge mclk);
         if (rst_n) begin
            if (buf_wr_en === 1'b1) begin
               check("wr_expected", exp_wr.size() > 0, 1);
               if (exp_wr.size() > 0) begin
                  e = exp_wr.pop_front();
                  check("wr_addr", buf_wr_addr, e.addr);
                  check("wr_data", buf_wr_data, e.data);
                  check("wr_bank", buf_bank, e.bank);
                  check("wr_latency", cyc, e.cyc);
               end
            end
            if (fft_start === 1'b1 && fft_ready) begin
               check("start_expected", exp_hs.size() > 0, 1);
               if (exp_hs.size() > 0) begin
                  hs = exp_hs.pop_front();
                  check("fft_bank", fft_bank, hs);
               end
            end
            if (prev_start === 1'b1 && !prev_ready)
               check("start_held", fft_start, 1);
            prev_start = fft_start;
            prev_ready = fft_ready;
         end else begin
            prev_start = 0;
            prev_ready = 0;
         end
      end
   end

   initial begin
      repeat (95000) @(posedge mclk);
      $display("FAIL watchdog: cycle budget exceeded at %0d", cyc);
      $fatal(1);
   end

   initial begin
      hold(1);
      do_reset();

      // first left half has no falling LRC edge: nothing captured
      send_frame(sample_t'($urandom), sample_t'($urandom), SW);
      send_frame(24'h000001, sample_t'($urandom), SW);
      send_frame(24'h000010, 24'hFFFFF0, SW);
      send_frame(24'h7FFFFF, 24'h7FFFFF, SW);
      send_frame(24'h800000, 24'h800000, SW);
      hold(20);
      check("drain_a", exp_wr.size(), 0);

      // reset 10 bits into a left word
      send_chan(0, sample_t'($urandom), 10);
      check("partial_not_queued", exp_wr.size(), 0);
      do_reset();
      send_frame(sample_t'($urandom), sample_t'($urandom), SW);

      // ramp frame: swap to bank 1, FFT reads bank 0
      send_writes(FL, 1, 0);
      hold(10);
      check("ramp_buf_bank", buf_bank, m_bank);
      check("ramp_fft_bank", fft_bank, m_fftb);
      check("ramp_overrun", overrun, m_over);
      check("ramp_start_seen", exp_hs.size(), 0);

      // FFT never finishes: next frame is dropped
      send_writes(FL, 0, 1);
      hold(10);
      check("drop_overrun", overrun, m_over);
      check("drop_buf_bank", buf_bank, m_bank);
      send_writes(3, 0, 0);
      issue_done();
      hold(20);
      check("drain_d", exp_wr.size(), 0);

      // fft_done on the frame-complete cycle
      do_reset();
      send_writes(FL, 0, 1);
      m_coincide = 1;
      fork
         send_writes(FL, 0, 1);
         done_at_complete();
      join
      hold(10);
      check("coincide_overrun", overrun, m_over);
      check("coincide_buf_bank", buf_bank, m_bank);
      check("coincide_fft_bank", fft_bank, m_fftb);

      hold(50);
      check("final_wr_queue", exp_wr.size(), 0);
      check("final_hs_queue", exp_hs.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
